// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register word offsets,
// FSM encodings and the STATUS word layout.
package irq_controller_pkg;

    localparam logic [2:0] REG_PEND   = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_EDGE   = 3'd2;
    localparam logic [2:0] REG_CLAIM  = 3'd3;
    localparam logic [2:0] REG_EOI    = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ASSERT  = 2'b01,
        SERVICE = 2'b10
    } state_t;

    function automatic logic [31:0] status_word(input state_t s, input logic [3:0] id);
        return {22'b0, s, 4'b0, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of vec and whether any
// bit is set at all.
module irq_prio_enc #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] vec,
    output logic            valid,
    output logic [3:0]      id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches level/edge device requests,
// masks them and runs a claim/complete handshake towards one CP0 HWInt line.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Sel,
    input  logic            WE,
    input  logic [4:0]      Addr,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] Src,
    output logic            IRQ
);

    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] edge_mode;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [3:0]      claimed_id;
    logic [3:0]      top_id;
    logic            top_valid;
    logic [2:0]      widx;
    logic            wr;
    logic            claim_fire;
    logic            eoi_fire;
    state_t          state;
    state_t          next_state;
    logic            unused_bits;

    assign widx        = Addr[4:2];
    assign wr          = Sel & WE;
    assign rise        = Src & ~src_q;
    assign eligible    = pend & mask;
    assign claim_fire  = wr && (widx == REG_CLAIM) && (state == ASSERT);
    assign eoi_fire    = wr && (widx == REG_EOI) && (state == SERVICE);
    assign unused_bits = ^{Addr[1:0], Din};

    irq_prio_enc #(.NSRC(NSRC)) u_prio (
        .vec   (eligible),
        .valid (top_valid),
        .id    (top_id)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (top_valid) next_state = ASSERT;
            ASSERT: begin
                if (claim_fire)      next_state = SERVICE;
                else if (!top_valid) next_state = IDLE;
            end
            SERVICE: if (eoi_fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= '0;
            pend       <= '0;
            mask       <= '0;
            edge_mode  <= '0;
            claimed_id <= 4'd0;
            state      <= IDLE;
            IRQ        <= 1'b0;
        end else begin
            src_q <= Src;
            state <= next_state;
            IRQ   <= (next_state == ASSERT);
            if (claim_fire) claimed_id <= top_id;
            if (wr && widx == REG_MASK) mask      <= Din[NSRC-1:0];
            if (wr && widx == REG_EDGE) edge_mode <= Din[NSRC-1:0];
            // A new rising edge outranks an EOI clearing the same bit.
            for (int i = 0; i < NSRC; i++) begin
                if (edge_mode[i]) begin
                    if (rise[i])
                        pend[i] <= 1'b1;
                    else if (eoi_fire && claimed_id == 4'(i))
                        pend[i] <= 1'b0;
                end else begin
                    pend[i] <= Src[i];
                end
            end
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (widx)
            REG_PEND:   Dout = 32'(pend);
            REG_MASK:   Dout = 32'(mask);
            REG_EDGE:   Dout = 32'(edge_mode);
            REG_CLAIM:  Dout = {top_valid, 27'b0, top_id};
            REG_STATUS: Dout = status_word(state, claimed_id);
            default:    Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register access, priority, masking,
// claim/EOI handshakes, illegal accesses and mid-service reset.
module tb_irq_controller;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            Sel;
    logic            WE;
    logic [4:0]      Addr;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic [NSRC-1:0] Src;
    logic            IRQ;

    int n_vec = 0;
    int n_mis = 0;

    irq_controller #(.NSRC(NSRC)) dut (
        .clk  (clk),
        .rst  (rst),
        .Sel  (Sel),
        .WE   (WE),
        .Addr (Addr),
        .Din  (Din),
        .Dout (Dout),
        .Src  (Src),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        Sel  = 1'b1;
        WE   = 1'b1;
        Addr = a;
        Din  = d;
        tick();
        Sel  = 1'b0;
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, Dout, exp);
    endtask

    initial begin
        rst = 1'b1; Sel = 1'b0; WE = 1'b0; Addr = 5'd0; Din = 32'd0; Src = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_irq", 32'(IRQ), 32'd0);
        chk_rd("rst_pend", 5'h00, 32'h0);
        chk_rd("rst_mask", 5'h04, 32'h0);
        chk_rd("rst_status", 5'h14, 32'h0);

        // 1: single edge source through a full claim/EOI handshake
        wr(5'h04, 32'h05);
        wr(5'h08, 32'h01);
        Src = 8'h01;
        tick();
        Src = 8'h00;
        chk_rd("t1_pend", 5'h00, 32'h01);
        check("t1_irq_lat", 32'(IRQ), 32'd0);
        tick();
        check("t1_irq", 32'(IRQ), 32'd1);
        chk_rd("t1_claim_rd", 5'h0C, 32'h8000_0000);
        wr(5'h0C, 32'h0);
        check("t1_irq_claimed", 32'(IRQ), 32'd0);
        chk_rd("t1_status_svc", 5'h14, 32'h200);
        wr(5'h10, 32'h0);
        chk_rd("t1_pend_eoi", 5'h00, 32'h00);
        chk_rd("t1_status_idle", 5'h14, 32'h000);
        tick();
        check("t1_irq_after", 32'(IRQ), 32'd0);

        // 2: priority among level sources
        wr(5'h08, 32'h00);
        wr(5'h04, 32'hFF);
        Src = 8'h0C;
        tick();
        tick();
        check("t2_irq", 32'(IRQ), 32'd1);
        chk_rd("t2_claim_id2", 5'h0C, 32'h8000_0002);
        wr(5'h0C, 32'h0);
        chk_rd("t2_status_svc", 5'h14, 32'h202);
        Src = 8'h08;
        tick();
        wr(5'h10, 32'h0);
        chk_rd("t2_status_idle", 5'h14, 32'h002);
        check("t2_irq_gap", 32'(IRQ), 32'd0);
        tick();
        check("t2_irq_reassert", 32'(IRQ), 32'd1);
        chk_rd("t2_claim_id3", 5'h0C, 32'h8000_0003);
        chk_rd("t2_status_assert", 5'h14, 32'h102);
        Src = 8'h00;
        tick();
        tick();
        check("t2_irq_drop", 32'(IRQ), 32'd0);

        // 3: masked level source, unmask, then re-mask during ASSERT
        wr(5'h04, 32'h00);
        Src = 8'h02;
        tick();
        tick();
        chk_rd("t3_pend", 5'h00, 32'h02);
        check("t3_irq_masked", 32'(IRQ), 32'd0);
        wr(5'h04, 32'h02);
        check("t3_irq_edge1", 32'(IRQ), 32'd0);
        tick();
        check("t3_irq_edge2", 32'(IRQ), 32'd1);
        wr(5'h04, 32'h00);
        tick();
        check("t3_irq_remask", 32'(IRQ), 32'd0);
        chk_rd("t3_status", 5'h14, 32'h002);
        Src = 8'h00;
        tick();

        // 4: EOI coinciding with a new rising edge on the claimed source
        wr(5'h08, 32'h10);
        wr(5'h04, 32'h10);
        Src = 8'h10;
        tick();
        tick();
        Src = 8'h00;
        wr(5'h0C, 32'h0);
        chk_rd("t4_status_svc", 5'h14, 32'h204);
        tick();
        Src = 8'h10;
        wr(5'h10, 32'h0);
        chk_rd("t4_pend_kept", 5'h00, 32'h10);
        chk_rd("t4_status_idle", 5'h14, 32'h004);
        check("t4_irq_gap", 32'(IRQ), 32'd0);
        tick();
        check("t4_irq_again", 32'(IRQ), 32'd1);
        chk_rd("t4_claim_id4", 5'h0C, 32'h8000_0004);
        wr(5'h0C, 32'h0);

        // 5: CLAIM in SERVICE and writes to an unmapped offset are ignored
        wr(5'h0C, 32'h0);
        chk_rd("t5_status_claim", 5'h14, 32'h204);
        wr(5'h18, 32'hFFFF_FFFF);
        chk_rd("t5_mask", 5'h04, 32'h10);
        chk_rd("t5_edge", 5'h08, 32'h10);
        chk_rd("t5_pend", 5'h00, 32'h10);
        chk_rd("t5_rd18", 5'h18, 32'h0);
        chk_rd("t5_rd1c", 5'h1C, 32'h0);

        // 6: reset while in SERVICE
        Src = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_irq", 32'(IRQ), 32'd0);
        chk_rd("t6_pend", 5'h00, 32'h0);
        chk_rd("t6_mask", 5'h04, 32'h0);
        chk_rd("t6_edge", 5'h08, 32'h0);
        chk_rd("t6_status", 5'h14, 32'h0);

        // EOI in IDLE must not clear a pending edge bit
        wr(5'h08, 32'h01);
        Src = 8'h01;
        tick();
        Src = 8'h00;
        wr(5'h10, 32'h0);
        chk_rd("t5_pend_eoi_idle", 5'h00, 32'h01);
        chk_rd("t5_status_eoi_idle", 5'h14, 32'h0);

        // Bits above NSRC-1 read back as zero
        wr(5'h04, 32'hFFFF_FFFF);
        chk_rd("mask_width", 5'h04, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
